regfile_multiport: RTL and testbench

//  Parametrised register file for the 64-bit datapath: NUM_RD combinational read ports, two write ports.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wsel.sv | 30 +++
 rtl/regfile_multiport.sv | 86 ++++++++
 tb/tb_regfile_multiport.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the 64-bit datapath register file.
// The widths here match the default DEPTH=32, DATA_W=64 configuration.
package regfile_pkg;

  localparam int REG_ADDR_W = $clog2(32);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [63:0]           reg_data_t;

  localparam reg_addr_t XZR = 5'd31;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } wport_t;

endpackage

// File: rtl/regfile_wsel.sv
// Per-register write select: picks the next value from the two write ports.
// Port 1 has priority over port 0. A zero register is never enabled.
module regfile_wsel
  import regfile_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int AW      = 5,
  parameter int IDX     = 0,
  parameter bit IS_ZERO = 1'b0
) (
  input  logic [1:0]             wr_en,
  input  logic [1:0][AW-1:0]     wr_addr,
  input  logic [1:0][DATA_W-1:0] wr_data,
  output logic                   we,
  output logic [DATA_W-1:0]      wd,
  output logic                   collide
);

  localparam logic [AW-1:0] MY_ADDR = AW'(IDX);

  logic hit0;
  logic hit1;

  assign hit0    = wr_en[0] && (wr_addr[0] == MY_ADDR) && !IS_ZERO;
  assign hit1    = wr_en[1] && (wr_addr[1] == MY_ADDR) && !IS_ZERO;
  assign we      = hit0 || hit1;
  assign wd      = hit1 ? wr_data[1] : wr_data[0];
  assign collide = hit0 && hit1;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD combinational read ports, two write ports, optional zero register.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          wr_en,
  input  logic [1:0][$clog2(DEPTH)-1:0]       wr_addr,
  input  logic [1:0][DATA_W-1:0]              wr_data,
  input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0] rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]       rd_data,
  output logic [DEPTH-1:0]                    written,
  output logic                                wr_collide
);

  localparam int            AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] ZADDR = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] wd_vec [DEPTH];
  logic [DEPTH-1:0]  we_vec;
  logic [DEPTH-1:0]  coll_vec;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wsel
    regfile_wsel #(
      .DATA_W  (DATA_W),
      .AW      (AW),
      .IDX     (g),
      .IS_ZERO ((ZERO_REG != 0) && (g == DEPTH - 1))
    ) u_wsel (
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .we      (we_vec[g]),
      .wd      (wd_vec[g]),
      .collide (coll_vec[g])
    );
  end

  // Storage stage: one-cycle write latency; reset clears data as well as flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      written    <= '0;
      wr_collide <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_vec[i]) begin
          mem[i]     <= wd_vec[i];
          written[i] <= 1'b1;
        end
      end
      wr_collide <= |coll_vec;
    end
  end

  // Read stage: combinational, each port independent.
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [DATA_W-1:0] val;

    always_comb begin
      val = mem[rd_addr[r]];
`ifdef RF_BYPASS_EN
      if (reset && wr_en[1] && (wr_addr[1] == rd_addr[r])) begin
        val = wr_data[1];
      end else if (reset && wr_en[0] && (wr_addr[0] == rd_addr[r])) begin
        val = wr_data[0];
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr[r] == ZADDR)) begin
        val = '0;
      end
    end

    assign rd_data[r] = val;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (default parameters, two read ports).
// Table-driven write/read vectors plus hand sequences for reset, bypass and async reset.
module tb_regfile_multiport;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      wr_en;
  logic [1:0][4:0] wr_addr;
  logic [1:0][63:0] wr_data;
  logic [1:0][4:0] rd_addr;
  logic [1:0][63:0] rd_data;
  logic [31:0]     written;
  logic            wr_collide;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_multiport #(
    .DATA_W   (64),
    .DEPTH    (32),
    .NUM_RD   (2),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .written    (written),
    .wr_collide (wr_collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [63:0] d0;
    logic [4:0]  a1;
    logic [63:0] d1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] exp0;
    logic [63:0] exp1;
    logic        exp_coll;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] exp_written;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b01, 5'd5,  64'hDEAD_BEEF_0123_4567, 5'd0,  64'h0,
                5'd5,  5'd0,  64'hDEAD_BEEF_0123_4567, 64'h0, 1'b0};
    vecs[1] = '{2'b11, 5'd7,  64'h1,                   5'd7,  64'h2,
                5'd7,  5'd5,  64'h2, 64'hDEAD_BEEF_0123_4567, 1'b1};
    vecs[2] = '{2'b00, 5'd7,  64'h9,                   5'd7,  64'h9,
                5'd7,  5'd5,  64'h2, 64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[3] = '{2'b10, 5'd9,  64'h77,                  5'd9,  64'h1111,
                5'd9,  5'd7,  64'h1111, 64'h2, 1'b0};
    vecs[4] = '{2'b11, 5'd10, 64'hAAAA,                5'd11, 64'hBBBB,
                5'd10, 5'd11, 64'hAAAA, 64'hBBBB, 1'b0};
    vecs[5] = '{2'b11, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,
                5'd31, 5'd31, 64'h0, 64'h0, 1'b0};
    vecs[6] = '{2'b01, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  64'h0,
                5'd31, 5'd5,  64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[7] = '{2'b11, 5'd12, 64'h3,                   5'd13, 64'h4,
                5'd12, 5'd13, 64'h3, 64'h4, 1'b0};
    vecs[8] = '{2'b01, 5'd5,  64'h55,                  5'd0,  64'h0,
                5'd5,  5'd5,  64'h55, 64'h55, 1'b0};
    vecs[9] = '{2'b10, 5'd1,  64'h66,                  5'd0,  64'h8000_0000_0000_0000,
                5'd0,  5'd1,  64'h8000_0000_0000_0000, 64'h0, 1'b0};

    // Reset held low with a write pending: nothing may land.
    reset   = 1'b0;
    wr_en   = 2'b11;
    wr_addr[0] = 5'd4;  wr_data[0] = 64'h1234;
    wr_addr[1] = 5'd6;  wr_data[1] = 64'h5678;
    rd_addr[0] = 5'd4;  rd_addr[1] = 5'd6;
    repeat (2) @(posedge clk);
    #2;
    check("reset_rd0", rd_data[0], 64'h0);
    check("reset_rd1", rd_data[1], 64'h0);
    check("reset_written", {32'h0, written}, 64'h0);
    check("reset_collide", {63'h0, wr_collide}, 64'h0);
    wr_en = 2'b00;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      rd_addr[0] = 5'(i);
      rd_addr[1] = 5'(31 - i);
      #1;
      check($sformatf("post_reset_rd_%0d", i), rd_data[0], 64'h0);
    end
    check("post_reset_written", {32'h0, written}, 64'h0);

    // Table-driven writes, reads after the edge.
    exp_written = '0;
    for (int v = 0; v < 10; v++) begin
      wr_en      = vecs[v].en;
      wr_addr[0] = vecs[v].a0;  wr_data[0] = vecs[v].d0;
      wr_addr[1] = vecs[v].a1;  wr_data[1] = vecs[v].d1;
      if (vecs[v].en[0] && vecs[v].a0 != 5'd31) exp_written[vecs[v].a0] = 1'b1;
      if (vecs[v].en[1] && vecs[v].a1 != 5'd31) exp_written[vecs[v].a1] = 1'b1;
      @(posedge clk); #1;
      wr_en      = 2'b00;
      rd_addr[0] = vecs[v].ra0;
      rd_addr[1] = vecs[v].ra1;
      #1;
      check($sformatf("vec%0d_rd0", v), rd_data[0], vecs[v].exp0);
      check($sformatf("vec%0d_rd1", v), rd_data[1], vecs[v].exp1);
      check($sformatf("vec%0d_collide", v), {63'h0, wr_collide}, {63'h0, vecs[v].exp_coll});
      check($sformatf("vec%0d_written", v), {32'h0, written}, {32'h0, exp_written});
    end

    // Same-cycle read of a register being written.
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 64'hA5;
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_same_cycle0", rd_data[0], 64'hA5);
    check("bypass_same_cycle1", rd_data[1], 64'hA5);
`else
    check("bypass_same_cycle0", rd_data[0], 64'h0);
    check("bypass_same_cycle1", rd_data[1], 64'h0);
`endif
    @(posedge clk); #1;
    wr_en = 2'b00;
    #1;
    check("bypass_next_cycle", rd_data[0], 64'hA5);

    // Dual-port same-cycle read: port 1 data wins when forwarding.
    wr_en = 2'b11; wr_addr[0] = 5'd3; wr_data[0] = 64'h10; wr_addr[1] = 5'd3; wr_data[1] = 64'h20;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_prio", rd_data[0], 64'h20);
`else
    check("bypass_prio", rd_data[0], 64'hA5);
`endif
    @(posedge clk); #1;
    wr_en = 2'b00;
    #1;
    check("prio_stored", rd_data[1], 64'h20);
    check("prio_collide", {63'h0, wr_collide}, 64'h1);

    // Zero register never forwards.
    wr_en = 2'b01; wr_addr[0] = 5'd31; wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_addr[0] = 5'd31;
    #1;
    check("xzr_no_bypass", rd_data[0], 64'h0);
    @(posedge clk); #1;
    wr_en = 2'b00;
    #1;
    check("xzr_after", rd_data[0], 64'h0);
    check("xzr_written", {63'h0, written[31]}, 64'h0);

    // Fill 0..30, then pulse reset between edges.
    for (int i = 0; i < 16; i++) begin
      wr_en      = (i == 15) ? 2'b01 : 2'b11;
      wr_addr[0] = 5'(2 * i);      wr_data[0] = 64'h100 + 64'(2 * i);
      wr_addr[1] = 5'(2 * i + 1);  wr_data[1] = 64'h100 + 64'(2 * i + 1);
      @(posedge clk); #1;
    end
    wr_en = 2'b00;
    rd_addr[0] = 5'd30; rd_addr[1] = 5'd17;
    #1;
    check("fill_rd30", rd_data[0], 64'h11E);
    check("fill_rd17", rd_data[1], 64'h111);
    check("fill_written", {32'h0, written}, 64'h7FFF_FFFF);
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rd_addr[0] = 5'(i);
      rd_addr[1] = 5'(31 - i);
      #0.1;
      check($sformatf("async_rst_rd_%0d", i), rd_data[0], 64'h0);
    end
    check("async_rst_written", {32'h0, written}, 64'h0);
    check("async_rst_collide", {63'h0, wr_collide}, 64'h0);
    wr_en = 2'b01; wr_addr[0] = 5'd8; wr_data[0] = 64'h99;
    @(posedge clk); #1;
    wr_en = 2'b00;
    reset = 1'b1;
    rd_addr[0] = 5'd8;
    #1;
    check("write_during_reset_lost", rd_data[0], 64'h0);
    check("written_during_reset", {32'h0, written}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
